ps2_mouse_device_tx: RTL
========================

// Module: ps2_mouse_device_tx
// PURPOSE
//  Device-side PS/2 mouse emulator: encodes {x,y,btn} into a standard 3-byte stream-mode packet and
//  transmits it on the PS/2 lines, generating ps2c itself as a real mouse does. It is the far end of
//  the host-side mouse receiver. Used to drive the board's mouse test design on-bench without a mouse.
// PARAMETERS
//  CLK_DIV   2500  clk cycles per ps2c half-period (10 kHz PS/2 clock at 50 MHz clk)
//  GAP_CYC   2500  idle cycles, lines released, between consecutive bytes of a packet
// PORTS
//  clk       in     1  system clock
//  rst_n     in     1  asynchronous, active-low reset
//  x         in     9  X movement, 9-bit two's complement (x[8] = sign)
//  y         in     9  Y movement, 9-bit two's complement (y[8] = sign)
//  btn       in     3  {middle,right,left}, 1 = pressed
//  send      in     1  1-cycle request; inputs captured on the same cycle if accepted
//  busy      out    1  high from acceptance until done_tick/abort_tick
//  done_tick out    1  1-cycle pulse: all 3 bytes sent
//  abort_tick out   1  1-cycle pulse: packet dropped due to host inhibit
//  ps2c      inout  1  open-drain: drives 0 or Z only
//  ps2d      inout  1  open-drain: drives 0 or Z only
// BEHAVIOUR
//  Reset: ps2c=Z, ps2d=Z, busy=0, done_tick=0, abort_tick=0, state=IDLE, byte index=0.
//  Packet: B0={1'b0,1'b0,y[8],x[8],1'b1,btn[2],btn[1],btn[0]}, B1=x[7:0], B2=y[7:0]; overflow bits always 0.
//  Frame per byte: start 0, D0..D7 LSB first, odd parity (~^data), stop 1 = 11 bits.
//  ps2c input passes a 2-flop synchronizer (c_s) before any use.
//  States:
//   IDLE: lines Z. send=1 -> latch B0..B2, busy=1, idx=0, -> WAIT. send while busy ignored (no queue).
//   WAIT: lines Z. c_s=1 -> BIT_H with bit=0; c_s=0 (host inhibit) -> stay, no timeout.
//   BIT_H: ps2c=Z; ps2d driven to frame bit (0 -> drive 0, 1 -> Z) from first cycle; lasts CLK_DIV.
//          Last cycle: c_s=0 -> host inhibit -> release both lines, abort_tick, busy=0, -> IDLE.
//          Else -> BIT_L.
//   BIT_L: ps2c driven 0, ps2d held; lasts CLK_DIV (host samples on falling edge).
//          Then bit<10 -> bit+1, BIT_H; bit=10 -> GAP (idx<2) or DONE (idx=2).
//   GAP: lines Z for GAP_CYC, idx+1, -> WAIT (inhibit re-checked before every byte).
//   DONE: one cycle: done_tick=1, busy=0 next, -> IDLE.
//  Inhibit check ignored during BIT_L (device itself holds ps2c low). Abort drops the whole packet;
//  no retransmission; host sees incomplete frame.
//  Timing with no inhibit: send to done_tick = 1 + 3*22*CLK_DIV + 2*GAP_CYC (+ WAIT cycles, +1 sync).
//  Half-period counter width = clog2(max(CLK_DIV,GAP_CYC)); counter reloads on every state change.
//  Reset mid-packet: lines released asynchronously, no done/abort pulse emitted.
//  done_tick and abort_tick are mutually exclusive; neither can coincide with send acceptance.
// TESTING  (CLK_DIV=4, GAP_CYC=8; bench model = host receiver sampling ps2d on ps2c fall, pull-ups)
//  1 send x=9'h005,y=9'h1FE,btn=3'b001 -> bytes 0x29 par 0, 0x05 par 1, 0xFE par 0; start/stop ok; done_tick at 1+264+16+sync.
//  2 x=9'h1FF,y=0,btn=3'b110 -> B0=0x1E par 1, B1=0xFF par 1, B2=0x00 par 1; busy high throughout.
//  3 send pulsed again mid-byte 1 with new values -> ignored; received packet matches first capture.
//  4 bench pulls ps2c low during BIT_H of byte 1 bit 4 -> abort_tick one pulse, ps2c/ps2d Z, busy=0, no done_tick.
//  5 bench holds ps2c low 200 cycles before send -> no edges while held; byte 0 starts ≤3 cycles after release.
//  6 rst_n asserted mid-byte 2 -> ps2c,ps2d Z and busy=0 immediately; next send transmits full packet.

Source files
------------

// File: rtl/ps2_mouse_device_tx_if.sv
// Handshake bundle between a packet source and the PS/2 mouse device transmitter.
interface ps2_mouse_device_tx_if;
  logic [8:0] x;
  logic [8:0] y;
  logic [2:0] btn;
  logic       send;
  logic       busy;
  logic       done_tick;
  logic       abort_tick;

  modport master (
    output x, y, btn, send,
    input  busy, done_tick, abort_tick
  );

  modport slave (
    input  x, y, btn, send,
    output busy, done_tick, abort_tick
  );
endinterface

// File: rtl/ps2_mouse_device_tx.sv
// Device-side PS/2 mouse emulator: sends a 3-byte stream-mode packet, generating ps2c itself.
module ps2_mouse_device_tx #(
  parameter int CLK_DIV = 2500,
  parameter int GAP_CYC = 2500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ps2_mouse_device_tx_if.slave        bus,
  inout  tri                          ps2c,
  inout  tri                          ps2d
);

  localparam int MAXC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, BIT_H, BIT_L, GAP, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_cnt;
  logic [1:0]      idx;
  logic [2:0][7:0] pkt;
  logic            c_meta;
  logic            c_s;
  logic            c_drv;
  logic            d_drv;
  logic            next_bit;

  // Frame bit n of a byte: start, D0..D7, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] n);
    logic r;
    case (n)
      4'd0:    r = 1'b0;
      4'd9:    r = ~^d;
      4'd10:   r = 1'b1;
      default: r = d[3'(n - 4'd1)];
    endcase
    return r;
  endfunction

  // Open-drain outputs: only ever pull low or release.
  assign ps2c = c_drv ? 1'b0 : 1'bz;
  assign ps2d = d_drv ? 1'b0 : 1'bz;

  // Bit that follows the one currently on the line.
  always_comb begin
    next_bit = frame_bit(pkt[idx], bit_cnt + 4'd1);
  end

  // Two-flop synchronizer for the shared clock line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta <= 1'b1;
      c_s    <= 1'b1;
    end else begin
      c_meta <= ps2c;
      c_s    <= c_meta;
    end
  end

  // Packet sequencer: frame bits, inter-byte gaps, host-inhibit abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      idx            <= '0;
      pkt            <= '0;
      c_drv          <= 1'b0;
      d_drv          <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done_tick  <= 1'b0;
      bus.abort_tick <= 1'b0;
    end else begin
      bus.done_tick  <= 1'b0;
      bus.abort_tick <= 1'b0;
      case (state)
        IDLE: begin
          c_drv <= 1'b0;
          d_drv <= 1'b0;
          // Holding off while abort_tick is high keeps acceptance and the pulse apart.
          if (bus.send && !bus.abort_tick) begin
            pkt[0]   <= {2'b00, bus.y[8], bus.x[8], 1'b1, bus.btn};
            pkt[1]   <= bus.x[7:0];
            pkt[2]   <= bus.y[7:0];
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (c_s) begin
            bit_cnt <= '0;
            cnt     <= CW'(CLK_DIV - 1);
            d_drv   <= 1'b1;
            state   <= BIT_H;
          end
        end
        BIT_H: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!c_s) begin
            d_drv          <= 1'b0;
            bus.busy       <= 1'b0;
            bus.abort_tick <= 1'b1;
            state          <= IDLE;
          end else begin
            c_drv <= 1'b1;
            cnt   <= CW'(CLK_DIV - 1);
            state <= BIT_L;
          end
        end
        BIT_L: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            c_drv <= 1'b0;
            if (bit_cnt != 4'd10) begin
              bit_cnt <= bit_cnt + 4'd1;
              d_drv   <= ~next_bit;
              cnt     <= CW'(CLK_DIV - 1);
              state   <= BIT_H;
            end else begin
              d_drv <= 1'b0;
              if (idx == 2'd2) begin
                bus.done_tick <= 1'b1;
                state         <= DONE;
              end else begin
                cnt   <= CW'(GAP_CYC - 1);
                state <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            idx   <= idx + 2'd1;
            state <= WAIT;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
